jt1942_dwnld: RTL
=================

// Module: jt1942_dwnld
// PURPOSE
//  Download sequencer between the HPS ioctl byte stream and the game core. Packs
//  ROM bytes into 16-bit words with a req/ack write to ROM memory, decodes
//  the PROM region into one-hot 4-bit PROM writes, and detects the header that
//  enables the invulnerability option. Holds the game in download/reset until
//  every word has been committed.
// PARAMETERS
//  ROM_AW     17        word-address width of ROM memory
//  PROM_START 25'h38000 first byte address of the PROM region (10 x 256 bytes)
//  PROM_N     10        number of PROMs; prom_we width
// PORTS
//  clk            in   1      system clock
//  rst_n          in   1      asynchronous reset, active low
//  ioctl_download in   1      download window from hps_io
//  ioctl_wr       in   1      byte strobe, one clk wide
//  ioctl_addr     in   25     byte address
//  ioctl_dout     in   8      byte data
//  rom_req        out  1      word write request, held until rom_ack
//  rom_ack        in   1      memory accepted current word
//  rom_addr       out  ROM_AW word address (= byte addr >> 1)
//  rom_data       out  16     {odd byte, even byte}
//  prog_addr      out  8      PROM address
//  prog_din       out  4      PROM data (low nibble of byte)
//  prom_we        out  PROM_N one-hot PROM write strobe, one clk
//  downloading    out  1      game held in download/reset
//  inv_ena        out  1      header bytes 10 83 00 80 matched
//  ovf            out  1      sticky: byte lost due to full buffer
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; buffer empty; header flags cleared.
//  FSM: IDLE -> LOAD on ioctl_download rise (also clears ovf, header flags).
//   LOAD -> FLUSH on ioctl_download fall. FLUSH -> IDLE when no half-word is
//   held, no word is pending, and rom_ack has been seen for the last word.
//  downloading = 1 in LOAD and FLUSH, 0 in IDLE; drops the cycle after FLUSH exits.
//  ROM path (addr < PROM_START): even byte is latched as low half; odd byte
//   completes the word, queued into a 2-entry FIFO. Out-of-order case: an odd byte
//   whose word address differs from the held half pushes {byte, 8'hFF}; a new
//   even byte while a half is held first pushes {8'hFF, held}.
//  FIFO head drives rom_req/rom_addr/rom_data; pop on rom_req & rom_ack;
//   rom_req rises no earlier than the cycle after the push (1-cycle latency).
//   Push and pop in the same cycle are legal, with count unchanged.
//  FIFO full on push: byte dropped, ovf <= 1, FIFO contents unchanged.
//  FLUSH: a held even half is pushed as {8'hFF, held}.
//  PROM path (PROM_START <= addr < PROM_START+256*PROM_N): n = (addr-PROM_START)>>8;
//   prom_we[n] pulses the cycle after ioctl_wr, with prog_addr=addr[7:0] and
//   prog_din=dout[3:0] valid in that same cycle. Addresses above the region
//   are ignored.
//  Header: flg[i] <= (dout==pattern[i]) on write to addr i (i=0..3);
//   inv_ena = &flg, registered, updated the cycle after the fourth byte.
//  ioctl_wr while IDLE: ignored. Any rst_n assertion mid-download: FIFO and
//   half-word discarded, rom_req drops immediately (async).
// STRUCTURE
//  Package jt1942_dwnld_pkg: FSM state enum {IDLE,LOAD,FLUSH}, HDR_PATTERN
//   (4 x 8-bit), PAD_BYTE=8'hFF.
//  Sub-module jt1942_dwnld_fifo: 2-deep, (ROM_AW+16)-bit FWFT FIFO with
//   push/pop/full/empty. Address decode and FSM stay in the top.
// TESTING
//  Bytes 0..3 = 10 83 00 80, ack tied 1 -> words 0x8310@0, 0x8000@1; inv_ena=1.
//  Same, with byte 3 = 81 -> inv_ena=0; word 1 = 0x8100.
//  ack held 0 for 3 words -> first two queued, third byte pair sets ovf=1;
//   release ack -> exactly two writes, downloading drops after second ack.
//  Odd-length: 5 ROM bytes then download fall -> final word {FF, byte4} @2.
//  Write at PROM_START+0x305 with dout 0xA7 -> prom_we=10'b0000001000,
//   prog_addr=05, prog_din=7; rom_req stays 0.
//  rst_n low while rom_req=1 in LOAD -> rom_req, downloading=0 same cycle;
//   after release, FIFO is empty and the FSM is in IDLE.

Source files
------------

// File: rtl/jt1942_dwnld_pkg.sv
// jt1942_dwnld_pkg: shared FSM state type and download constants
package jt1942_dwnld_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;
  localparam logic [3:0][7:0] HDR_PATTERN = {8'h80, 8'h00, 8'h83, 8'h10};
  localparam logic [7:0] PAD_BYTE = 8'hFF;
endpackage

// File: rtl/jt1942_dwnld_fifo.sv
// jt1942_dwnld_fifo: 2-deep first-word-fall-through FIFO
// ports: push/din write when not full; pop/dout read head when not empty; full, empty status
module jt1942_dwnld_fifo #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic wp_q, wp_d, rp_q, rp_d, do_push, do_pop;
  logic [1:0] cnt_q, cnt_d;
  assign full  = cnt_q[1];
  assign empty = cnt_q == 2'd0;
  assign dout  = mem_q[rp_q];
  always_comb begin
    do_push = push & ~full;
    do_pop = pop & ~empty;
    mem_d = mem_q;
    if (do_push) mem_d[wp_q] = din;
    wp_d = wp_q ^ do_push;
    rp_d = rp_q ^ do_pop;
    cnt_d = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem_q <= '{default: '0};
      wp_q <= 1'b0;
      rp_q <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/jt1942_dwnld.sv
// jt1942_dwnld: ioctl download sequencer packing ROM words, writing PROMs, detecting header
// ports: ioctl_* byte stream in; rom_req/rom_ack/rom_addr/rom_data word writes out;
//        prog_addr/prog_din/prom_we PROM writes; downloading, inv_ena, ovf status
module jt1942_dwnld
  import jt1942_dwnld_pkg::*;
#(
  parameter int          ROM_AW     = 17,
  parameter logic [24:0] PROM_START = 25'h38000,
  parameter int          PROM_N     = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              rom_req,
  input  logic              rom_ack,
  output logic [ROM_AW-1:0] rom_addr,
  output logic [15:0]       rom_data,
  output logic [7:0]        prog_addr,
  output logic [3:0]        prog_din,
  output logic [PROM_N-1:0] prom_we,
  output logic              downloading,
  output logic              inv_ena,
  output logic              ovf
);
  state_t state_q, state_d;
  logic dl_q, hv_q, hv_d, ovf_q, ovf_d, inv_q, inv_d;
  logic [7:0] half_q, half_d, pa_q, pa_d;
  logic [3:0] flg_q, flg_d, pd_q, pd_d;
  logic [ROM_AW-1:0] ha_q, ha_d, waddr;
  logic [PROM_N-1:0] we_q, we_d;
  logic push, full, empty, wr, is_rom, is_prom, match;
  logic [ROM_AW+15:0] push_word, head;
  logic [16:0] pidx;
  jt1942_dwnld_fifo #(.W(ROM_AW + 16)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .din(push_word),
    .pop(rom_req & rom_ack), .dout(head), .full(full), .empty(empty)
  );
  assign rom_req     = ~empty;
  assign rom_addr    = head[ROM_AW+15:16];
  assign rom_data    = head[15:0];
  assign downloading = state_q != IDLE;
  assign inv_ena     = inv_q;
  assign ovf         = ovf_q;
  assign prom_we     = we_q;
  assign prog_addr   = pa_q;
  assign prog_din    = pd_q;
  assign wr      = ioctl_wr & (state_q == LOAD);
  assign waddr   = ioctl_addr[ROM_AW:1];
  assign pidx    = ioctl_addr[24:8] - PROM_START[24:8];
  assign is_rom  = ioctl_addr < PROM_START;
  assign is_prom = !is_rom && pidx < 17'(PROM_N);
  assign match   = hv_q && ha_q == waddr;
  always_comb begin
    state_d = state_q;
    half_d = half_q;
    hv_d = hv_q;
    ha_d = ha_q;
    ovf_d = ovf_q;
    flg_d = flg_q;
    we_d = '0;
    pa_d = pa_q;
    pd_d = pd_q;
    push = 1'b0;
    push_word = {ha_q, PAD_BYTE, half_q};
    if (state_q == IDLE && ioctl_download && !dl_q) begin
      state_d = LOAD;
      ovf_d = 1'b0;
      flg_d = '0;
    end
    if (state_q == LOAD && !ioctl_download && dl_q) state_d = FLUSH;
    if (state_q == FLUSH && hv_q && !full) begin
      push = 1'b1;
      hv_d = 1'b0;
    end
    if (state_q == FLUSH && !hv_q && empty) state_d = IDLE;
    if (wr && ioctl_addr < 25'd4) flg_d[ioctl_addr[1:0]] = ioctl_dout == HDR_PATTERN[ioctl_addr[1:0]];
    if (wr && is_rom && !ioctl_addr[0]) begin
      // a stranded even half goes out padded before the new one takes its place
      push = hv_q;
      half_d = ioctl_dout;
      hv_d = 1'b1;
      ha_d = waddr;
    end
    if (wr && is_rom && ioctl_addr[0]) begin
      push = 1'b1;
      push_word = {waddr, ioctl_dout, match ? half_q : PAD_BYTE};
      hv_d = match ? 1'b0 : hv_q;
    end
    if (wr && is_prom) begin
      we_d = PROM_N'(1) << pidx;
      pa_d = ioctl_addr[7:0];
      pd_d = ioctl_dout[3:0];
    end
    if (push && full) ovf_d = 1'b1;
    inv_d = &flg_d;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      dl_q <= 1'b0;
      half_q <= '0;
      hv_q <= 1'b0;
      ha_q <= '0;
      ovf_q <= 1'b0;
      flg_q <= '0;
      inv_q <= 1'b0;
      we_q <= '0;
      pa_q <= '0;
      pd_q <= '0;
    end else begin
      state_q <= state_d;
      dl_q <= ioctl_download;
      half_q <= half_d;
      hv_q <= hv_d;
      ha_q <= ha_d;
      ovf_q <= ovf_d;
      flg_q <= flg_d;
      inv_q <= inv_d;
      we_q <= we_d;
      pa_q <= pa_d;
      pd_q <= pd_d;
    end
endmodule
